// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator: emits an oversample tick every
// divisor_int + divisor_frac/2^FRAC_W main_clk cycles, plus bit-centre and bit-boundary pulses.
module uart_baud_gen_frac #(
  parameter int CLK_FREQ   = 150_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              main_clk,
  input  logic              sreset,
  input  logic              enable,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  divisor_int,
  input  logic [FRAC_W-1:0] divisor_frac,
  input  logic              resync,
  output logic              tick_os,
  output logic              tick_mid,
  output logic              tick_bit,
  output logic              running,
  output logic              cfg_err,
  output logic [7:0]        status
);

  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam longint unsigned OS_RATE  = 64'(BAUDRATE) * 64'(OVERSAMPLE);
  localparam longint unsigned DEF_INT  = 64'(CLK_FREQ) / OS_RATE;
  localparam longint unsigned DEF_FRAC = ((64'(CLK_FREQ) % OS_RATE) << FRAC_W) / OS_RATE;
  localparam logic [DIV_W-1:0]  DEF_INT_V  = DEF_INT[DIV_W-1:0];
  localparam logic [FRAC_W-1:0] DEF_FRAC_V = DEF_FRAC[FRAC_W-1:0];

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID = SUB_W'(OVERSAMPLE / 2);

  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
    $error("uart_baud_gen_frac: OVERSAMPLE must be 8 or 16");
  end
  if (DEF_INT < 2 || (DEF_INT >> DIV_W) != 0) begin : g_bad_div
    $error("uart_baud_gen_frac: default integer divisor out of range");
  end

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic              cfg_err_q, cfg_err_d;
  logic              tick_os_q, tick_os_d;
  logic              tick_mid_q, tick_mid_d;
  logic              tick_bit_q, tick_bit_d;
  logic              running_q, running_d;
  logic [7:0]        status_q, status_d;

  logic [FRAC_W:0]   sum;
  logic              carry;
  logic              period_end;
  logic              load_ok;
  logic              apply_now;
  logic [SUB_W-1:0]  sub_nx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sub_d      = sub_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    cfg_err_d  = cfg_err_q;
    tick_os_d  = 1'b0;
    tick_mid_d = 1'b0;
    tick_bit_d = 1'b0;
    apply_now  = 1'b0;

    sum   = {1'b0, acc_q} + {1'b0, act_frac_q};
    carry = sum[FRAC_W];
    // A carried period is one cycle longer; the counter then reaches act_int itself,
    // which still fits in DIV_W bits.
    period_end = carry ? (cnt_q == act_int_q) : (cnt_q == act_int_q - DIV_W'(1));
    sub_nx     = (sub_q == SUB_MAX) ? '0 : sub_q + SUB_W'(1);
    load_ok    = cfg_load && (divisor_int >= DIV_W'(2));

    if (cfg_load) cfg_err_d = !load_ok;

    if (state_q != ST_RUN) begin
      apply_now = 1'b1;
      if (enable) state_d = ST_RUN;
    end else if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      acc_d     = '0;
      sub_d     = '0;
      apply_now = 1'b1;
    end else if (resync) begin
      // Resync wins over a coincident period end: that tick is dropped.
      cnt_d     = '0;
      acc_d     = '0;
      sub_d     = '0;
      apply_now = 1'b1;
    end else if (period_end) begin
      cnt_d      = '0;
      acc_d      = sum[FRAC_W-1:0];
      sub_d      = sub_nx;
      tick_os_d  = 1'b1;
      tick_mid_d = (sub_nx == SUB_MID);
      tick_bit_d = (sub_nx == '0);
      apply_now  = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // A mid-period load waits in the shadow until the next period start.
    if (load_ok) begin
      sh_int_d  = divisor_int;
      sh_frac_d = divisor_frac;
      if (apply_now) begin
        act_int_d  = divisor_int;
        act_frac_d = divisor_frac;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (pend_q && apply_now) begin
      act_int_d  = sh_int_q;
      act_frac_d = sh_frac_q;
      pend_d     = 1'b0;
    end

    running_d = (state_d == ST_RUN);
    status_d  = {6'd0, state_d};
  end

  always_ff @(posedge main_clk) begin
    if (sreset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      sub_q      <= '0;
      act_int_q  <= DEF_INT_V;
      act_frac_q <= DEF_FRAC_V;
      sh_int_q   <= DEF_INT_V;
      sh_frac_q  <= DEF_FRAC_V;
      pend_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      tick_os_q  <= 1'b0;
      tick_mid_q <= 1'b0;
      tick_bit_q <= 1'b0;
      running_q  <= 1'b0;
      status_q   <= 8'd1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sub_q      <= sub_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      cfg_err_q  <= cfg_err_d;
      tick_os_q  <= tick_os_d;
      tick_mid_q <= tick_mid_d;
      tick_bit_q <= tick_bit_d;
      running_q  <= running_d;
      status_q   <= status_d;
    end
  end

  assign tick_os  = tick_os_q;
  assign tick_mid = tick_mid_q;
  assign tick_bit = tick_bit_q;
  assign running  = running_q;
  assign cfg_err  = cfg_err_q;
  assign status   = status_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: vector table, directed interval sequences and a
// randomized run against a period-arithmetic reference model.
module tb_uart_baud_gen_frac;

  logic        main_clk = 1'b0;
  logic        sreset = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_load = 1'b0;
  logic [15:0] divisor_int = '0;
  logic [3:0]  divisor_frac = '0;
  logic        resync = 1'b0;
  logic        tick_os, tick_mid, tick_bit, running, cfg_err;
  logic [7:0]  status;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_baud_gen_frac dut (
    .main_clk(main_clk), .sreset(sreset), .enable(enable), .cfg_load(cfg_load),
    .divisor_int(divisor_int), .divisor_frac(divisor_frac), .resync(resync),
    .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit),
    .running(running), .cfg_err(cfg_err), .status(status)
  );

  always #5 main_clk = ~main_clk;
  always @(posedge main_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: period k after a restart lasts int + floor((a0+(k+1)f)/16) - floor((a0+kf)/16).
  bit m_ok = 0;
  int m_run, m_el, m_k, m_acc0, m_int, m_frac, m_pend, m_shi, m_shf, m_err, m_ticks;
  logic e_os = 0, e_mid = 0, e_bit = 0;

  function automatic int per_len();
    return m_int + (m_acc0 + (m_k + 1) * m_frac) / 16 - (m_acc0 + m_k * m_frac) / 16;
  endfunction

  task automatic m_apply(input int i, input int f);
    m_acc0 = (m_acc0 + m_k * m_frac) % 16;
    m_k = 0;
    m_int = i;
    m_frac = f;
  endtask

  task automatic m_restart();
    m_el = 0; m_k = 0; m_acc0 = 0; m_ticks = 0;
  endtask

  always @(posedge main_clk) begin
    automatic bit valid;
    automatic int di = int'(divisor_int);
    automatic int df = int'(divisor_frac);
    e_os = 0; e_mid = 0; e_bit = 0;
    if (sreset) begin
      m_ok = 1; m_run = 0; m_int = 81; m_frac = 6; m_err = 0; m_pend = 0;
      m_restart();
    end else if (m_ok) begin
      valid = cfg_load && di >= 2;
      if (cfg_load) m_err = valid ? 0 : 1;
      if (!m_run) begin
        if (valid) begin m_int = di; m_frac = df; end
        if (enable) begin m_run = 1; m_restart(); end
      end else if (!enable || resync) begin
        if (valid) m_apply(di, df);
        else if (m_pend) m_apply(m_shi, m_shf);
        m_pend = 0;
        m_restart();
        if (!enable) m_run = 0;
      end else begin
        m_el++;
        if (m_el == per_len()) begin
          m_ticks++;
          e_os = 1;
          e_mid = (m_ticks % 16) == 8;
          e_bit = (m_ticks % 16) == 0;
          m_k++;
          m_el = 0;
          if (valid) m_apply(di, df);
          else if (m_pend) m_apply(m_shi, m_shf);
          m_pend = 0;
        end else if (valid) begin
          m_shi = di; m_shf = df; m_pend = 1;
        end
      end
    end
    #1;
    if (m_ok) begin
      chk("mdl tick_os", tick_os, e_os);
      chk("mdl tick_mid", tick_mid, e_mid);
      chk("mdl tick_bit", tick_bit, e_bit);
      chk("mdl running", running, m_run);
      chk("mdl status", status, m_run ? 2 : 1);
      chk("mdl cfg_err", cfg_err, m_err);
    end
  end

  task automatic wait_tick(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(posedge main_clk); #1;
      if (tick_os) begin t = cyc; break; end
    end
    if (t < 0) begin
      checks++; failures++;
      $display("FAIL wait_tick: no tick_os within %0d cycles", lim);
    end
  endtask

  typedef struct {
    logic rst, en, ld, rs;
    logic [15:0] di;
    logic [3:0] df;
    logic os, run, err;
    logic [7:0] st;
  } vec_t;
  localparam int NV = 24;
  vec_t tbl[NV];

  initial begin
    int t, t0, t1, prev, n;
    logic bit_seen;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, t0, t1, prev, n;
    logic bit_seen;
    //            rst en ld rs  di df  os run err st
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 1, 0, 3, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 1};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 2};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 2};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 2};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 2};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 2};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 2};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 2};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    tbl[12] = '{0, 0, 1, 0, 2, 0, 0, 0, 0, 1};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 2};
    tbl[14] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 2};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 2};
    tbl[16] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 2};
    tbl[17] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 2};
    tbl[18] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 2};
    tbl[19] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 2};
    tbl[20] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 2};
    tbl[21] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 2};
    tbl[22] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 2};
    tbl[23] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1};

    for (int i = 0; i < NV; i++) begin
      @(negedge main_clk);
      sreset = tbl[i].rst; enable = tbl[i].en; cfg_load = tbl[i].ld; resync = tbl[i].rs;
      divisor_int = tbl[i].di; divisor_frac = tbl[i].df;
      @(posedge main_clk); #1;
      chk($sformatf("vec%0d tick_os", i), tick_os, tbl[i].os);
      chk($sformatf("vec%0d running", i), running, tbl[i].run);
      chk($sformatf("vec%0d cfg_err", i), cfg_err, tbl[i].err);
      chk($sformatf("vec%0d status", i), status, tbl[i].st);
    end

    // Defaults 81 + 6/16: per-tick intervals, mid/bit placement, 16-tick span.
    @(negedge main_clk);
    sreset = 0; enable = 1; cfg_load = 0; resync = 0; divisor_int = 0; divisor_frac = 0;
    t0 = cyc + 1; prev = t0;
    for (int i = 1; i <= 16; i++) begin
      wait_tick(200, t);
      chk($sformatf("dflt interval %0d", i), t - prev, 81 + (6 * i) / 16 - (6 * (i - 1)) / 16);
      if (i == 8) chk("dflt tick_mid on 8th", tick_mid, 1);
      if (i == 16) begin
        chk("dflt tick_bit on 16th", tick_bit, 1);
        chk("dflt 16-tick span", t - t0, 1302);
      end
      prev = t;
    end

    // Load 10/0 mid-period: in-flight period keeps 81, then 10s.
    @(negedge main_clk); cfg_load = 1; divisor_int = 10; divisor_frac = 0;
    @(negedge main_clk); cfg_load = 0;
    wait_tick(200, t);
    chk("load10 in-flight period", t - prev, 81);
    prev = t;
    for (int i = 0; i < 3; i++) begin
      wait_tick(50, t); chk("load10 interval", t - prev, 10); prev = t;
    end

    // Invalid load (int=1) then a valid load of 4.
    @(negedge main_clk); cfg_load = 1; divisor_int = 1; divisor_frac = 3;
    @(posedge main_clk); #1; chk("bad load cfg_err", cfg_err, 1);
    @(negedge main_clk); cfg_load = 0;
    wait_tick(50, t); chk("bad load period kept", t - prev, 10); prev = t;
    @(negedge main_clk); cfg_load = 1; divisor_int = 4; divisor_frac = 0;
    @(negedge main_clk); cfg_load = 0;
    wait_tick(50, t);
    chk("load4 in-flight period", t - prev, 10);
    chk("load4 cfg_err cleared", cfg_err, 0);
    prev = t;
    for (int i = 0; i < 3; i++) begin
      wait_tick(50, t); chk("load4 interval", t - prev, 4); prev = t;
    end

    // Resync 5 cycles before an expected tick at int=10.
    @(negedge main_clk); cfg_load = 1; divisor_int = 10; divisor_frac = 0;
    @(negedge main_clk); cfg_load = 0;
    wait_tick(50, t);
    wait_tick(50, t1); chk("resync pre interval", t1 - t, 10);
    repeat (5) @(negedge main_clk);
    resync = 1;
    @(negedge main_clk); resync = 0;
    wait_tick(50, t); chk("resync next tick", t - t1, 15);
    n = 1; bit_seen = tick_bit;
    while (!bit_seen && n < 20) begin
      wait_tick(50, t); n++; bit_seen = tick_bit;
    end
    chk("resync tick_bit after 16", n, 16);

    // Enable drop mid-period, then reset mid-run restores defaults.
    repeat (3) @(negedge main_clk);
    enable = 0;
    @(posedge main_clk); #1;
    chk("disable running", running, 0);
    chk("disable no tick", tick_os, 0);
    chk("disable status", status, 1);
    @(negedge main_clk); cfg_load = 1; divisor_int = 0;
    @(posedge main_clk); #1; chk("idle bad load cfg_err", cfg_err, 1);
    @(negedge main_clk); cfg_load = 0; enable = 1;
    repeat (20) @(negedge main_clk);
    sreset = 1;
    @(posedge main_clk); #1;
    chk("rst status", status, 1);
    chk("rst running", running, 0);
    chk("rst tick_os", tick_os, 0);
    chk("rst cfg_err", cfg_err, 0);
    @(negedge main_clk); sreset = 0;
    t0 = cyc + 1; prev = t0;
    for (int i = 1; i <= 3; i++) begin
      wait_tick(200, t);
      chk("post-rst interval", t - prev, (i == 3) ? 82 : 81);
      prev = t;
    end

    // Randomized run; the model checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge main_clk);
      sreset = ($urandom_range(0, 999) < 5);
      enable = ($urandom_range(0, 99) < 95);
      resync = ($urandom_range(0, 99) < 2);
      cfg_load = ($urandom_range(0, 99) < 3);
      divisor_int = 16'($urandom_range(0, 12));
      divisor_frac = 4'($urandom_range(0, 15));
    end
    @(negedge main_clk);
    sreset = 0; enable = 0; resync = 0; cfg_load = 0;
    @(posedge main_clk); #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
